// File: rtl/hdmi_pkg.sv
// rtl/hdmi_pkg.sv - shared types and constants for the HDMI pattern writer
package hdmi_pkg;

    localparam int COORD_W_DEF = 11;
    localparam int RGB_W       = 24;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_CHECK = 2'd1;
    localparam logic [1:0] PAT_GRAD  = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LATCH,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

endpackage

// File: rtl/hdmi_pattern_gen.sv
// rtl/hdmi_pattern_gen.sv - registered pixel colour for the next pixel to be written
module hdmi_pattern_gen
    import hdmi_pkg::*;
#(
    parameter logic [RGB_W-1:0] SOLID_RGB = 24'hFFFFFF
)
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    input  logic [7:0]       x,
    input  logic [7:0]       y,
    input  logic [2:0]       bar_idx,
    input  logic [1:0]       pattern,
    output logic [RGB_W-1:0] pixel
);

    rgb_t pixel_q;
    rgb_t pixel_d;

    // The enable is deasserted while the slave stalls, so the colour holds with its address.
    always_comb begin
        pixel_d = pixel_q;
        if (en) begin
            case (pattern)
                PAT_BARS:  pixel_d = '{r: {8{bar_idx[2]}}, g: {8{bar_idx[1]}}, b: {8{bar_idx[0]}}};
                PAT_CHECK: pixel_d = (x[5] ^ y[5]) ? rgb_t'(24'hFFFFFF) : rgb_t'(24'h000000);
                PAT_GRAD:  pixel_d = '{r: x, g: x, b: y};
                default:   pixel_d = rgb_t'(SOLID_RGB);
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pixel_q <= '0;
        end else begin
            pixel_q <= pixel_d;
        end
    end

    assign pixel = pixel_q;

endmodule

// File: rtl/hdmi_pattern_writer.sv
// rtl/hdmi_pattern_writer.sv - Avalon-MM master filling the HDMI frame buffer with a test pattern
module hdmi_pattern_writer
    import hdmi_pkg::*;
#(
    parameter int               ADDR_W    = 22,
    parameter int               COORD_W   = COORD_W_DEF,
    parameter logic [RGB_W-1:0] SOLID_RGB = 24'hFFFFFF
)
(
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic               start,
    input  logic [1:0]         pattern_sel,
    input  logic [COORD_W-1:0] horz,
    input  logic [COORD_W-1:0] vert,
    output logic [ADDR_W-1:0]  avm_address,
    output logic               avm_write,
    output logic [RGB_W-1:0]   avm_writedata,
    input  logic               avm_waitrequest,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [15:0]        frame_count
);

    state_t             state_q, state_d;
    logic [1:0]         pat_q, pat_d;
    logic [COORD_W-1:0] horz_q, horz_d;
    logic [COORD_W-1:0] vert_q, vert_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic [COORD_W-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               err_q, err_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;

    logic [COORD_W-1:0] horz_div8;
    logic [COORD_W-1:0] bar_w;
    logic               accept;
    logic               last_x;
    logic               last_y;
    logic               gen_en;

    assign horz_div8 = horz_q >> 3;
    assign bar_w     = (horz_div8 == '0) ? {{(COORD_W-1){1'b0}}, 1'b1} : horz_div8;
    assign accept    = (state_q == ST_WRITE) && !avm_waitrequest;
    assign last_x    = (x_q == horz_q - 1'b1);
    assign last_y    = (y_q == vert_q - 1'b1);

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        horz_d      = horz_q;
        vert_d      = vert_q;
        x_d         = x_q;
        y_d         = y_q;
        bar_cnt_d   = bar_cnt_q;
        bar_idx_d   = bar_idx_q;
        addr_d      = addr_q;
        err_d       = err_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LATCH;
                    pat_d   = pattern_sel;
                    err_d   = 1'b0;
                end
            end
            ST_LATCH: begin
                horz_d    = horz;
                vert_d    = vert;
                x_d       = '0;
                y_d       = '0;
                addr_d    = '0;
                bar_cnt_d = '0;
                bar_idx_d = '0;
                if (horz == '0 || vert == '0) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (accept) begin
                    addr_d = addr_q + 1'b1;
                    if (last_x) begin
                        x_d       = '0;
                        y_d       = y_q + 1'b1;
                        bar_cnt_d = '0;
                        bar_idx_d = '0;
                        if (last_y) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                        if (bar_cnt_q == bar_w - 1'b1) begin
                            bar_cnt_d = '0;
                            bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
                        end else begin
                            bar_cnt_d = bar_cnt_q + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!err_q) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The generator is fed the coordinates of the pixel that will be presented next cycle.
    assign gen_en = (state_q == ST_LATCH) || accept;

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q     <= ST_IDLE;
            pat_q       <= PAT_BARS;
            horz_q      <= '0;
            vert_q      <= '0;
            x_q         <= '0;
            y_q         <= '0;
            bar_cnt_q   <= '0;
            bar_idx_q   <= '0;
            addr_q      <= '0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            horz_q      <= horz_d;
            vert_q      <= vert_d;
            x_q         <= x_d;
            y_q         <= y_d;
            bar_cnt_q   <= bar_cnt_d;
            bar_idx_q   <= bar_idx_d;
            addr_q      <= addr_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    hdmi_pattern_gen #(
        .SOLID_RGB (SOLID_RGB)
    ) u_gen (
        .clk     (clk_clk),
        .resetn  (reset_reset_n),
        .en      (gen_en),
        .x       (x_d[7:0]),
        .y       (y_d[7:0]),
        .bar_idx (bar_idx_d),
        .pattern (pat_q),
        .pixel   (avm_writedata)
    );

    assign avm_address = addr_q;
    assign avm_write   = (state_q == ST_WRITE);
    assign busy        = (state_q == ST_LATCH) || (state_q == ST_WRITE);
    assign done        = (state_q == ST_DONE);
    assign err         = err_q;
    assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_hdmi_pattern_writer.sv
// tb/tb_hdmi_pattern_writer.sv - randomized self-checking bench for hdmi_pattern_writer
module tb_hdmi_pattern_writer;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [10:0] horz = 11'd0;
    logic [10:0] vert = 11'd0;
    logic [21:0] avm_address;
    logic        avm_write;
    logic [23:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] frame_count;

    hdmi_pattern_writer dut (
        .clk_clk         (clk_clk),
        .reset_reset_n   (reset_reset_n),
        .start           (start),
        .pattern_sel     (pattern_sel),
        .horz            (horz),
        .vert            (vert),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .frame_count     (frame_count)
    );

    always #5 clk_clk = ~clk_clk;

    int checks = 0;
    int passed = 0;
    int stall_pct = 0;
    int stall_cnt = 0;
    int stall_viol = 0;
    int bad_idx = 0;
    logic [21:0] wr_addr[$];
    logic [23:0] wr_data[$];
    logic        prev_stall = 1'b0;
    logic [21:0] prev_addr = '0;
    logic [23:0] prev_data = '0;

    // Passive monitor: records every accepted write and any change while stalled.
    always @(negedge clk_clk) begin
        if (reset_reset_n && avm_write && !avm_waitrequest) begin
            wr_addr.push_back(avm_address);
            wr_data.push_back(avm_writedata);
        end
        if (reset_reset_n && avm_write && avm_waitrequest) stall_cnt++;
        if (prev_stall && reset_reset_n &&
            (avm_write !== 1'b1 || avm_address !== prev_addr || avm_writedata !== prev_data))
            stall_viol++;
        prev_stall = reset_reset_n && avm_write && avm_waitrequest;
        prev_addr  = avm_address;
        prev_data  = avm_writedata;
    end

    function automatic logic [23:0] ref_pixel(int pat, int x, int y, int w);
        int bw, idx;
        logic [7:0] xb, yb;
        xb = 8'(x % 256);
        yb = 8'(y % 256);
        case (pat)
            0: begin
                bw = w / 8;
                if (bw < 1) bw = 1;
                idx = x / bw;
                if (idx > 7) idx = 7;
                return {((idx & 4) != 0) ? 8'hFF : 8'h00,
                        ((idx & 2) != 0) ? 8'hFF : 8'h00,
                        ((idx & 1) != 0) ? 8'hFF : 8'h00};
            end
            1: return ((((x / 32) + (y / 32)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            2: return {xb, xb, yb};
            default: return 24'hFFFFFF;
        endcase
    endfunction

    // Counts writes that disagree with a w x h frame of pattern pat; wrong length counts too.
    function automatic int frame_errors(int w, int h, int pat);
        int e = 0;
        bad_idx = -1;
        if (wr_addr.size() != w * h) e++;
        for (int i = 0; i < wr_addr.size() && i < w * h; i++) begin
            if (wr_addr[i] !== 22'(i) || wr_data[i] !== ref_pixel(pat, i % w, i / w, w)) begin
                if (bad_idx < 0) bad_idx = i;
                e++;
            end
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk_clk);
        #1;
        avm_waitrequest = ($urandom_range(99) < stall_pct);
        @(negedge clk_clk);
    endtask

    task automatic pulse_start(input int w, input int h, input int pat);
        wr_addr.delete();
        wr_data.delete();
        stall_cnt = 0;
        horz = 11'(w);
        vert = 11'(h);
        pattern_sel = 2'(pat);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(output int cyc, output bit ok);
        cyc = 2;
        ok = 1'b0;
        for (int i = 0; i < 30000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset_reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if ({avm_write, avm_address, avm_writedata, busy, done, err, frame_count} !== '0)
            $display("FAIL reset_values: got write=%b addr=%0d data=%h busy=%b done=%b err=%b fc=%0d, want all 0",
                     avm_write, avm_address, avm_writedata, busy, done, err, frame_count);
        else passed++;
        reset_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_bars();
        int cyc, e;
        bit ok;
        stall_pct = 0;
        pulse_start(16, 2, 0);
        run_to_done(cyc, ok);
        checks++;
        if (!ok || cyc != 35) $display("FAIL bars_done_cycle: got %0d (ok=%b), want 35", cyc, ok);
        else passed++;
        e = frame_errors(16, 2, 0);
        checks++;
        if (e != 0) $display("FAIL bars_frame: %0d bad writes, first at %0d, count %0d want 32", e, bad_idx, wr_addr.size());
        else passed++;
        checks++;
        if (wr_data.size() < 17 || wr_data[0] !== 24'h000000 || wr_data[1] !== 24'h000000 ||
            wr_data[2] !== 24'h0000FF || wr_data[15] !== 24'hFFFFFF || wr_data[16] !== 24'h000000)
            $display("FAIL bars_landmarks: pixels 0,1,2,15,16 not 000000,000000,0000FF,FFFFFF,000000 (size %0d)", wr_data.size());
        else passed++;
        tick();
        checks++;
        if (frame_count !== 16'd1) $display("FAIL bars_frame_count: got %0d, want 1", frame_count);
        else passed++;
    endtask

    task automatic test_checker_stall();
        int cyc, e;
        bit ok;
        stall_pct = 50;
        stall_viol = 0;
        pulse_start(64, 64, 1);
        run_to_done(cyc, ok);
        checks++;
        if (!ok) $display("FAIL checker_timeout: done not seen");
        else passed++;
        e = frame_errors(64, 64, 1);
        checks++;
        if (e != 0) $display("FAIL checker_frame: %0d bad writes, first at %0d, count %0d want 4096", e, bad_idx, wr_addr.size());
        else passed++;
        checks++;
        if (stall_viol != 0) $display("FAIL checker_stall_stable: %0d changes while stalled, want 0", stall_viol);
        else passed++;
        checks++;
        if (cyc != 3 + 4096 + stall_cnt) $display("FAIL checker_stall_cost: done at %0d, want %0d", cyc, 3 + 4096 + stall_cnt);
        else passed++;
        checks++;
        if (wr_data.size() != 4096 || wr_data[32] !== 24'hFFFFFF || wr_data[32 * 64 + 32] !== 24'h000000)
            $display("FAIL checker_landmarks: (32,0)/(32,32) not FFFFFF/000000 (size %0d)", wr_data.size());
        else passed++;
        stall_pct = 0;
        tick();
    endtask

    task automatic test_zero_res();
        int cyc;
        bit ok;
        logic [15:0] fc;
        fc = frame_count;
        pulse_start(0, 5, 2);
        run_to_done(cyc, ok);
        checks++;
        if (!ok || cyc != 3 || wr_addr.size() != 0)
            $display("FAIL zero_res_done: done at %0d ok=%b writes=%0d, want 3 and 0 writes", cyc, ok, wr_addr.size());
        else passed++;
        tick();
        checks++;
        if (err !== 1'b1 || frame_count !== fc)
            $display("FAIL zero_res_err: err=%b fc=%0d, want err=1 fc=%0d", err, frame_count, fc);
        else passed++;
        pulse_start(4, 1, 3);
        checks++;
        if (err !== 1'b0) $display("FAIL zero_res_clear: err=%b, want 0 after start", err);
        else passed++;
        run_to_done(cyc, ok);
        tick();
    endtask

    task automatic test_busy_ignore();
        int cyc, e, pat;
        bit ok;
        pat = $urandom_range(3);
        pulse_start(8, 4, pat);
        repeat (5) tick();
        horz = 11'd20;
        vert = 11'd1;
        pattern_sel = 2'(pat + 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_to_done(cyc, ok);
        e = frame_errors(8, 4, pat);
        checks++;
        if (!ok || e != 0) $display("FAIL busy_ignore_frame: %0d bad writes, first at %0d, ok=%b", e, bad_idx, ok);
        else passed++;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) $display("FAIL start_at_done: busy=%b, want 0", busy);
        else passed++;
        tick();
    endtask

    task automatic test_random_frames();
        int w, h, pat, cyc, e;
        bit ok;
        logic [15:0] fc;
        stall_pct = 30;
        for (int n = 0; n < 4; n++) begin
            w = $urandom_range(1, 40);
            h = $urandom_range(1, 6);
            pat = $urandom_range(3);
            fc = frame_count;
            pulse_start(w, h, pat);
            run_to_done(cyc, ok);
            e = frame_errors(w, h, pat);
            checks++;
            if (!ok || e != 0) $display("FAIL random_frame_%0d: %0dx%0d pat %0d, %0d bad, first at %0d", n, w, h, pat, e, bad_idx);
            else passed++;
            tick();
            checks++;
            if (frame_count !== fc + 16'd1) $display("FAIL random_fc_%0d: got %0d, want %0d", n, frame_count, fc + 16'd1);
            else passed++;
        end
        stall_pct = 0;
        tick();
    endtask

    task automatic test_reset_mid_frame();
        int cyc, e;
        bit ok;
        pulse_start(8, 4, 2);
        for (int i = 0; i < 100 && wr_addr.size() < 10; i++) tick();
        checks++;
        if (avm_write !== 1'b1 || avm_address !== 22'd10) $display("FAIL reset_mid_pos: write=%b addr=%0d, want 1/10", avm_write, avm_address);
        else passed++;
        reset_reset_n = 1'b0;
        tick();
        checks++;
        if (avm_write !== 1'b0 || done !== 1'b0) $display("FAIL reset_mid_write: write=%b done=%b, want 0/0", avm_write, done);
        else passed++;
        tick();
        reset_reset_n = 1'b1;
        tick();
        checks++;
        if (frame_count !== 16'd0 || done !== 1'b0) $display("FAIL reset_mid_fc: fc=%0d done=%b, want 0/0", frame_count, done);
        else passed++;
        pulse_start(8, 4, 0);
        run_to_done(cyc, ok);
        e = frame_errors(8, 4, 0);
        checks++;
        if (!ok || e != 0 || frame_count !== 16'd0)
            $display("FAIL reset_mid_refill: %0d bad, first at %0d, fc=%0d want 0 before end", e, bad_idx, frame_count);
        else passed++;
        tick();
        checks++;
        if (frame_count !== 16'd1) $display("FAIL reset_mid_final_fc: got %0d, want 1", frame_count);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_bars();
        test_checker_stall();
        test_zero_res();
        test_busy_ignore();
        test_random_frames();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/hdmi_pattern_writer.md
# hdmi_pattern_writer

Avalon-MM write master that fills the HDMI frame buffer with a selectable test pattern, one 24-bit RGB pixel per accepted write. It sits directly upstream of the HDMI Qsys core on the memory-mapped clock domain. It reads the active resolution (`horz`/`vert`) from that core and writes linear pixel addresses into the core's frame-buffer slave. The test bench uses it to exercise the avalon_mm path without a CPU.

## Interface
Parameters:
- `ADDR_W`, 22: Avalon word-address width.
- `COORD_W`, 11: coordinate and resolution width; matches the HDMI core.
- `SOLID_RGB`, 24'hFFFFFF: colour for pattern 3.

Ports:
- `clk_clk`, in, 1: sole clock; connected to `hdmi_clk_mm`.
- `reset_reset_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: one-cycle request to fill one frame.
- `pattern_sel`, in, 2: pattern select; 0 = colour bars, 1 = checkerboard, 2 = gradient, 3 = solid.
- `horz`, in, COORD_W: active width in pixels, from `hdmi_horz`.
- `vert`, in, COORD_W: active height in lines, from `hdmi_vert`.
- `avm_address`, out, ADDR_W: pixel word address.
- `avm_write`, out, 1: write request.
- `avm_writedata`, out, 24: pixel value {R[23:16], G[15:8], B[7:0]}.
- `avm_waitrequest`, in, 1: slave stall.
- `busy`, out, 1: high from LATCH through WRITE.
- `done`, out, 1: one-cycle pulse at frame end.
- `err`, out, 1: sticky; set on zero resolution, cleared by the next accepted `start`.
- `frame_count`, out, 16: completed frames; wraps at 65535→0.

## Operation
- FSM states: IDLE, LATCH, WRITE, DONE.
- **IDLE**: waits for `start`=1, then moves to LATCH. `pattern_sel` is captured on the same edge.
- **LATCH**: captures `horz` and `vert`, and clears x, y, address, and the bar counter.
  - If either value is 0: set `err`, go to DONE, issue no writes.
  - Otherwise go to WRITE.
- **WRITE**: `avm_write`=1.
  - Address, data and write are held stable while `avm_waitrequest`=1.
  - On accept (`avm_write` and not `avm_waitrequest`), advance the pixel:
    - x increments and the address increments.
    - At x = horz-1: x wraps to 0 and y increments.
  - Accept of pixel (horz-1, vert-1) → DONE.
- **DONE**: `done`=1 for one cycle; `frame_count` increments only if `err` is clear; next state is IDLE.
- Address is linear, y·horz + x, held as a running counter. No multiplier is used.
- Patterns:
  - Colour bars: 8 bars, bar width bw = max(horz>>3, 1). A bar counter counts to bw, then the bar index increments. The index saturates at 7 and resets at line start. Bar i colour = {R=i[2]?FF:00, G=i[1]?FF:00, B=i[0]?FF:00}.
  - Checkerboard: x[5]^y[5] ? FFFFFF : 000000.
  - Gradient: {x[7:0], x[7:0], y[7:0]}.
  - Solid: SOLID_RGB.
- `start` while busy or in DONE is ignored.
- Changes to `horz`, `vert` or `pattern_sel` after LATCH have no effect until the next frame.

## Timing
- Reset values: state IDLE, `avm_write` 0, `avm_address` 0, `avm_writedata` 0, `busy` 0, `done` 0, `err` 0, `frame_count` 0.
- `start` sampled high at edge N → LATCH during N+1 → first `avm_write` during N+2.
- With `avm_waitrequest` held 0: one pixel per cycle.
  - `done` pulses one cycle after the last accept.
  - Start to `done` takes 2 + W·H + 1 cycles.
- Each stall cycle adds exactly one cycle. There is no lookahead and no data change while stalled.
- `avm_writedata` is registered and presented with its address in the same cycle.
- Reset asserted mid-frame: `avm_write` is 0 from the following edge and no partial `done` is produced. The master must tolerate abandoning a stalled write; the HDMI slave owns the consequences.
- `start` coincident with `done` is ignored; re-issue in IDLE.

## Structure
- Shared package `hdmi_pkg`:
  - state enum;
  - pattern-select constants (PAT_BARS, PAT_CHECK, PAT_GRAD, PAT_SOLID);
  - COORD_W default;
  - RGB struct/width constant.
- One sub-module, `hdmi_pattern_gen`: registered pixel-colour function of (x, y, bar index, pattern). It is stall-aware through an enable input. Address and FSM logic stay in the top level.

## Test plan
- **Reset**: hold reset_reset_n=0 for 3 cycles → all outputs at reset values, `avm_write`=0.
- **Clean fill, 16×2 bars, no wait**:
  - 32 writes at addresses 0..31, `done` at cycle 35 after start, `frame_count`=1.
  - Pixels 0–1 = 000000, pixel 2 = 0000FF, pixel 15 = FFFFFF.
  - Row 1 restarts at bar 0 (address 16 = 000000).
- **Random waitrequest (~50%), 64×64 checkerboard**:
  - 4096 unique accepts in order.
  - Address and data stable across every stall.
  - Pixel (32,0) = FFFFFF, pixel (32,32) = 000000.
- **Zero resolution**: horz=0 → no `avm_write`, `done` one cycle after LATCH, `err`=1, `frame_count` unchanged. Next valid start clears `err`.
- **start during busy, and horz change mid-frame**: both ignored; address sequence matches the latched 8×4 frame (32 writes).
- **Reset asserted at pixel 10 of 8×4**: `avm_write` low next edge. Next start rewrites from address 0, and `frame_count` stays 0 until that frame completes.
